// File: rtl/hex_pkg.sv
// -----------------------------------------------------------------------------
// hex_pkg
// Shared types and constants for the hex_counter block.
//   nibble_t    : 4-bit value type driven into the hex decoder
//   deb_state_t : key debouncer FSM states
//   HEX_MAX/MIN : count range limits, used for wrap detection
//   nib_step()  : one modulo-16 step up or down
// -----------------------------------------------------------------------------
package hex_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    localparam nibble_t HEX_MAX = 4'hF;
    localparam nibble_t HEX_MIN = 4'h0;

    // Modulo-16 step; the 4-bit result width provides the wrap.
    function automatic nibble_t nib_step(input nibble_t v, input logic up);
        return up ? (v + 4'd1) : (v - 4'd1);
    endfunction

endpackage

// File: rtl/hex_counter_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer plus debounce FSM for an active-low push-button.
// Issues exactly one registered step strobe per accepted press; holding the
// key never repeats.
//   clk_i     in  : system clock
//   rst_i     in  : synchronous active-high reset
//   key_n_i   in  : raw button, active-low, asynchronous
//   step_o    out : one-cycle strobe per accepted press
// -----------------------------------------------------------------------------
module key_debounce
    import hex_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic step_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          key_up;

    // Synchronized level: 1 = released, 0 = pressed.
    assign key_up = sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    // The cycle that enters a WAIT state is not counted; the counter then
    // needs DEBOUNCE_CYCLES further stable cycles before the state is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!key_up) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_up) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (key_up) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_up) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign step_o = step_q;

endmodule

// File: rtl/hex_counter.sv
// -----------------------------------------------------------------------------
// hex_counter
// 4-bit counter feeding a seven-segment hex decoder. Advances once per
// prescaled tick while RUN=1 and once per debounced key press; DIR selects
// up (1) or down (0). WRAP pulses on the edge VALUE wraps.
//   CLOCK_50  in  : system clock
//   RESET     in  : synchronous active-high reset
//   KEY_STEP  in  : raw push-button, active-low, asynchronous
//   RUN       in  : enable automatic counting
//   DIR       in  : 1 = up, 0 = down
//   LOAD      in  : (HEX_COUNTER_LOAD_EN only) load LOAD_VAL, clear prescaler
//   LOAD_VAL  in  : (HEX_COUNTER_LOAD_EN only) value to load
//   VALUE     out : registered count
//   WRAP      out : registered one-cycle wrap pulse
// Optional feature macro: HEX_COUNTER_LOAD_EN
// -----------------------------------------------------------------------------
module hex_counter
    import hex_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_STEP,
    input  logic       RUN,
    input  logic       DIR,
`ifdef HEX_COUNTER_LOAD_EN
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
`endif
    output logic [3:0] VALUE,
    output logic       WRAP
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic          tick_q, tick_d;
    nibble_t       value_q, value_d;
    logic          wrap_q, wrap_d;
    logic          step;
    logic          load;
    nibble_t       load_val;

`ifdef HEX_COUNTER_LOAD_EN
    assign load     = LOAD;
    assign load_val = LOAD_VAL;
`else
    assign load     = 1'b0;
    assign load_val = HEX_MIN;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i  (CLOCK_50),
        .rst_i  (RESET),
        .key_n_i(KEY_STEP),
        .step_o (step)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            psc_q   <= '0;
            tick_q  <= 1'b0;
            value_q <= HEX_MIN;
            wrap_q  <= 1'b0;
        end else begin
            psc_q   <= psc_d;
            tick_q  <= tick_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        psc_d   = '0;
        tick_d  = 1'b0;
        value_d = value_q;
        wrap_d  = 1'b0;

        // tick is registered, so it is applied one edge after the terminal
        // count; this also lets a tick pending when RUN drops still land.
        if (RUN) begin
            if (psc_q == PSC_LAST) begin
                tick_d = 1'b1;
            end else begin
                psc_d = psc_q + PW'(1);
            end
        end

        // step and tick merge into a single event: at most one increment.
        if (step || tick_q) begin
            value_d = nib_step(value_q, DIR);
            wrap_d  = DIR ? (value_q == HEX_MAX) : (value_q == HEX_MIN);
        end

        // Load wins over any simultaneous count event and restarts the period.
        if (load) begin
            value_d = load_val;
            wrap_d  = 1'b0;
            psc_d   = '0;
            tick_d  = 1'b0;
        end
    end

    assign VALUE = value_q;
    assign WRAP  = wrap_q;

endmodule

// File: tb/tb_hex_counter.sv
module tb_hex_counter;

    localparam int T = 4;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst, key, run, dir;
    logic [3:0] value;
    logic       wrap;
`ifdef HEX_COUNTER_LOAD_EN
    logic       load;
    logic [3:0] load_val;
`endif

    always #5 clk = ~clk;

    hex_counter #(.TICK_DIV(T), .DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .KEY_STEP(key),
        .RUN     (run),
        .DIR     (dir),
`ifdef HEX_COUNTER_LOAD_EN
        .LOAD    (load),
        .LOAD_VAL(load_val),
`endif
        .VALUE   (value),
        .WRAP    (wrap)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int wrap_seen = 0;

    // Reference model: counts run lengths rather than tracking FSM states.
    //  - auto: the change lands one edge after every T-th consecutive RUN=1 edge
    //  - key : key seen two edges late; D+1 equal samples accept a press/release
    logic [3:0] m_val;
    logic       m_wrap;
    int         rl, zrun, orun;
    logic       tick_p, step_p, pressed, s1, s2;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic ld;
        logic [3:0] lv;
        ld = 1'b0;
        lv = 4'h0;
`ifdef HEX_COUNTER_LOAD_EN
        ld = load;
        lv = load_val;
`endif
        if (rst) begin
            m_val = 4'h0; m_wrap = 1'b0; rl = 0; tick_p = 1'b0; step_p = 1'b0;
            s1 = 1'b1; s2 = 1'b1; zrun = 0; orun = 0; pressed = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (ld) begin
                m_val = lv;
            end else if (step_p || tick_p) begin
                if (dir) begin
                    m_wrap = (m_val == 4'hF);
                    m_val  = m_val + 4'd1;
                end else begin
                    m_wrap = (m_val == 4'h0);
                    m_val  = m_val - 4'd1;
                end
            end
            rl     = run ? (rl + 1) % T : 0;
            tick_p = run && (rl == 0);
            if (ld) begin
                rl = 0;
                tick_p = 1'b0;
            end
            if (s2 == 1'b0) begin zrun++; orun = 0; end
            else begin orun++; zrun = 0; end
            step_p = 1'b0;
            if (!pressed && zrun >= D + 1) begin
                pressed = 1'b1;
                step_p  = 1'b1;
            end else if (pressed && orun >= D + 1) begin
                pressed = 1'b0;
            end
            s2 = s1;
            s1 = key;
        end
    endtask

    // One clock: update model on the edge, compare 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model_value", value, m_val);
        check("model_wrap", wrap, m_wrap);
        if (wrap === 1'b1) wrap_seen++;
    endtask

    task automatic press();
        key = 1'b0;
        repeat (D + 4) cyc();
        key = 1'b1;
        repeat (D + 4) cyc();
    endtask

    initial begin
        int hold;
        rst = 1'b1; run = 1'b1; dir = 1'b1; key = 1'b1;
`ifdef HEX_COUNTER_LOAD_EN
        load = 1'b0; load_val = 4'h0;
`endif
        // Reset held 2 cycles with RUN=1
        repeat (2) cyc();
        check("rst_value", value, 0);
        check("rst_wrap", wrap, 0);

        // First auto change T edges after RUN is first sampled out of reset
        rst = 1'b0;
        cyc();
        repeat (3) begin
            cyc();
            check("pre_first_tick", value, 0);
        end
        cyc();
        check("first_tick", value, 1);

        // Auto up-wrap over 64 cycles: 16 steps, a single F->0 wrap
        wrap_seen = 0;
        repeat (64) cyc();
        check("upwrap_count", wrap_seen, 1);
        check("upwrap_end", value, 1);

        // Down-wrap by a clean key press held 10 cycles
        rst = 1'b1; run = 1'b0; dir = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        wrap_seen = 0;
        key = 1'b0;
        cyc();                       // edge k: first low sample
        repeat (4) cyc();
        cyc();
        check("key_k5", value, 0);
        cyc();
        check("key_k6", value, 4'hF);
        repeat (3) cyc();
        check("key_held", value, 4'hF);
        key = 1'b1;
        repeat (10) cyc();
        check("key_wrap_count", wrap_seen, 1);
        check("key_no_repeat", value, 4'hF);

        // Bounce: toggle every cycle, then settle high
        for (int i = 0; i < 20; i++) begin
            key = (i % 2 == 1);
            cyc();
        end
        key = 1'b1;
        repeat (10) cyc();
        check("bounce_reject", value, 4'hF);

        // Six presses up from F reach 5
        dir = 1'b1;
        repeat (6) press();
        check("presses_to_5", value, 5);

        // Align a press with a tick: press lands at k+6, RUN rises at k+2
        key = 1'b0;
        cyc();                       // k
        cyc();                       // k+1
        run = 1'b1;
        cyc();                       // k+2 = r
        repeat (3) cyc();
        check("simul_before", value, 5);
        cyc();                       // k+6 = r+T
        check("simul_once", value, 6);
        cyc();
        check("simul_not7", value, 6);
        run = 1'b0;
        key = 1'b1;
        repeat (8) cyc();

`ifdef HEX_COUNTER_LOAD_EN
        // Load coincident with a tick: tick is discarded, period restarts
        rst = 1'b1; run = 1'b1; dir = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();                       // r
        repeat (3) cyc();            // tick now pending for edge r+4
        load = 1'b1; load_val = 4'hA;
        cyc();
        check("load_value", value, 4'hA);
        check("load_wrap", wrap, 0);
        load = 1'b0;
        repeat (4) cyc();
        check("load_hold", value, 4'hA);
        cyc();
        check("load_next", value, 4'hB);
`endif

        // Randomized traffic against the model
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                key  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 10);
            end
            hold--;
            if ($urandom_range(0, 49) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            rst = ($urandom_range(0, 299) == 0);
`ifdef HEX_COUNTER_LOAD_EN
            load     = ($urandom_range(0, 39) == 0);
            load_val = 4'($urandom_range(0, 15));
`endif
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hex_counter.md
# hex_counter

Sequential source stage that produces the 4-bit value driving the board's seven-segment hex decoder. Holds a nibble that advances automatically at a prescaled rate when running, or one step per debounced push-button press. Count direction is switch-selectable. Output `VALUE` connects directly to the decoder's 4-bit select input.

## Interface
- `TICK_DIV`, default 50_000_000: `CLOCK_50` cycles per automatic count step; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synchronized key must remain stable before a press or release is accepted; legal range ≥ 1.
- `CLOCK_50`  in  1  system clock; the only clock.
- `RESET`  in  1  synchronous, active-high reset.
- `KEY_STEP`  in  1  raw push-button, active-low, asynchronous to `CLOCK_50`.
- `RUN`  in  1  1 = automatic counting enabled.
- `DIR`  in  1  1 = count up, 0 = count down; sampled on each count event.
- `VALUE`  out  4  current count, fed to the hex decoder.
- `WRAP`  out  1  one-cycle pulse on the cycle `VALUE` wraps (F→0 up, 0→F down).

## Operation
- Reset, sampled on a `CLOCK_50` edge with `RESET`=1: `VALUE`=0, `WRAP`=0, prescaler=0, synchronizer flops=1 (key released), debouncer in IDLE with its counter=0. Reset overrides every other input, including mid-debounce and mid-prescale.
- Key path: two-flop synchronizer on `KEY_STEP`, then debounce FSM:
  - IDLE: synchronized key=0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: key=0 for `DEBOUNCE_CYCLES` consecutive cycles → HELD, one-cycle `step` strobe issued. Key=1 at any point → IDLE.
  - HELD: key=1 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: key=1 for `DEBOUNCE_CYCLES` cycles → IDLE. Key=0 → HELD.
  - Exactly one step per accepted press, regardless of hold time. No auto-repeat.
- Prescaler: runs while `RUN`=1 and counts 0..`TICK_DIV`-1. On the terminal count it wraps to 0 and issues a one-cycle `tick`. While `RUN`=0 it is held at 0.
- Count event = `step` OR `tick`. If both occur in the same cycle, `VALUE` changes by exactly one.
- On a count event: `VALUE` ← `VALUE`+1 if `DIR`=1, otherwise `VALUE`−1, modulo 16.
- `WRAP` is asserted on the same edge that `VALUE` takes a wrapped value. It is 0 on all other cycles.

## Timing
- All outputs are registered. There is no combinational path from any input to `VALUE` or `WRAP`.
- Key latency: `KEY_STEP` low is first sampled on edge k. The `step` strobe is high during the cycle following edge k+2+`DEBOUNCE_CYCLES`. `VALUE` updates on the next edge, for a total of `DEBOUNCE_CYCLES`+3 edges.
- Auto latency: when `RUN` rises (first sampled high on edge r), the first `VALUE` change occurs on edge r+`TICK_DIV`. Subsequent changes occur every `TICK_DIV` cycles.
- `RUN` falling clears the prescaler on the next edge. A pending tick in that same cycle is still applied.
- `DIR` changes take effect on the next count event. There is no glitch or skipped value.

## Configuration
- `HEX_COUNTER_LOAD_EN` defined: adds ports `LOAD` (in, 1) and `LOAD_VAL` (in, 4).
  - `LOAD`=1 on an edge: `VALUE` ← `LOAD_VAL`, the prescaler is cleared to 0, and `WRAP`=0.
  - `LOAD` has priority over a simultaneous `step`/`tick`, which is discarded.
  - `RESET` has priority over `LOAD`.
- Not defined: these ports are absent and behaviour is exactly as above.

## Structure
- Shared package `hex_pkg` holds:
  - `nibble_t` (logic [3:0]);
  - `deb_state_t` enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - constants `HEX_MAX`=4'hF and `HEX_MIN`=4'h0.
- One sub-module, `key_debounce`: contains the synchronizer and the FSM, is parameterized by `DEBOUNCE_CYCLES`, and outputs the `step` strobe.
- Prescaler and count register stay in `hex_counter`.

## Test plan
Unless noted, use `TICK_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- Reset: assert `RESET` for 2 cycles with `RUN`=1 → `VALUE`=0 and `WRAP`=0. After release, first change to 1 occurs 4 edges later.
- Auto up-wrap: `RUN`=1, `DIR`=1, 64 cycles → `VALUE` steps 1..F then 0. `WRAP` is high for exactly one cycle at the F→0 transition.
- Down-wrap by key: `RUN`=0, `DIR`=0, `VALUE`=0, one clean press held 10 cycles → `VALUE`=F exactly 6 edges after the first low sample, `WRAP` pulses once, and no further change while held.
- Bounce rejection: `KEY_STEP` toggles low/high every cycle for 20 cycles, then stays high → `VALUE` is unchanged.
- Simultaneous event: align an accepted press with a tick, `VALUE`=5, `DIR`=1 → `VALUE`=6, not 7.
- With `HEX_COUNTER_LOAD_EN`: `LOAD`=1, `LOAD_VAL`=A coincident with a tick → `VALUE`=A and `WRAP`=0. The next tick occurs 4 edges later, giving B.
